roach_dram_arbiter: RTL and testbench

// Shares the single ROACH2 DRAM command port between two clients (A, B), e.g. a burst writer and a burst reader.

---
 rtl/roach_dram_arbiter_if.sv | 24 ++
 rtl/roach_dram_arbiter.sv | 156 +++++++++++++++
 tb/tb_roach_dram_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/roach_dram_arbiter_if.sv
// rtl/roach_dram_arbiter_if.sv - one client's command and read-return port on the DRAM arbiter
interface roach_dram_arbiter_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 288
);
  logic                  valid;
  logic                  rwn;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  last;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (
    output valid, rwn, addr, wdata, last,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  valid, rwn, addr, wdata, last,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/roach_dram_arbiter.sv
// rtl/roach_dram_arbiter.sv - round-robin burst arbiter sharing the ROACH2 DRAM port between two clients
module roach_dram_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int MAX_BURST  = 64,
  parameter int TAG_DEPTH  = 16,
  parameter int RD_BEATS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  roach_dram_arbiter_if.slave   a,
  roach_dram_arbiter_if.slave   b,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [287:0]          dram_wdata,
  output logic                  dram_rwn,
  output logic                  dram_cmd_valid,
  input  logic                  dram_cmd_ack,
  input  logic [287:0]          dram_rd_data,
  input  logic                  dram_rd_valid,
  output logic [1:0]            grant,
  output logic                  rd_err
);

  localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = $clog2(MAX_BURST + 1);
  localparam int BEAT_W = $clog2(RD_BEATS + 1);

  // State encoding doubles as the one-hot {B,A} grant output.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } state_t;

  state_t           state;
  logic             ptr_b;
  logic [CNT_W-1:0] burst_cnt;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [TAG_AW:0]      wr_ptr;
  logic [TAG_AW:0]      rd_ptr;
  logic [BEAT_W-1:0]    beat_cnt;

  logic tag_empty;
  logic tag_full;
  logic tag_head;
  logic sel_last;
  logic accept;
  logic release_burst;
  logic push;
  logic last_beat;

  assign tag_empty = (wr_ptr == rd_ptr);
  assign tag_full  = (wr_ptr[TAG_AW] != rd_ptr[TAG_AW]) &&
                     (wr_ptr[TAG_AW-1:0] == rd_ptr[TAG_AW-1:0]);
  assign tag_head  = tag_mem[rd_ptr[TAG_AW-1:0]];

  always_comb begin
    dram_addr      = '0;
    dram_wdata     = '0;
    dram_rwn       = 1'b1;
    dram_cmd_valid = 1'b0;
    sel_last       = 1'b0;
    case (state)
      GRANT_A: begin
        dram_addr      = a.addr;
        dram_wdata     = a.wdata;
        dram_rwn       = a.rwn;
        dram_cmd_valid = a.valid & ~(a.rwn & tag_full);
        sel_last       = a.last;
      end
      GRANT_B: begin
        dram_addr      = b.addr;
        dram_wdata     = b.wdata;
        dram_rwn       = b.rwn;
        dram_cmd_valid = b.valid & ~(b.rwn & tag_full);
        sel_last       = b.last;
      end
      default: ;
    endcase
  end

  assign accept        = dram_cmd_valid & dram_cmd_ack;
  assign release_burst = accept & (sel_last | (burst_cnt == CNT_W'(MAX_BURST - 1)));
  assign push          = accept & dram_rwn;
  assign last_beat     = (beat_cnt == BEAT_W'(RD_BEATS - 1));

  assign a.ready = (state == GRANT_A) & accept;
  assign b.ready = (state == GRANT_B) & accept;
  assign grant   = state;

  // Read data is steered purely by the oldest outstanding tag; no extra pipeline stage.
  assign a.rdata  = dram_rd_data;
  assign b.rdata  = dram_rd_data;
  assign a.rvalid = dram_rd_valid & ~tag_empty & ~tag_head;
  assign b.rvalid = dram_rd_valid & ~tag_empty &  tag_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr_b     <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (a.valid && (!ptr_b || !b.valid)) begin
            state <= GRANT_A;
          end else if (b.valid && (ptr_b || !a.valid)) begin
            state <= GRANT_B;
          end
        end
        GRANT_A, GRANT_B: begin
          if (release_burst) begin
            state     <= IDLE;
            ptr_b     <= (state == GRANT_A);
            burst_cnt <= '0;
          end else if (accept) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr[TAG_AW-1:0]] <= (state == GRANT_B);
    end
  end

  // A full FIFO keeps stalling reads even when a pop lands the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
      rd_err   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (TAG_AW + 1)'(1);
      end
      if (dram_rd_valid) begin
        if (tag_empty) begin
          rd_err <= 1'b1;
        end else if (last_beat) begin
          beat_cnt <= '0;
          rd_ptr   <= rd_ptr + (TAG_AW + 1)'(1);
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_roach_dram_arbiter.sv
// tb/tb_roach_dram_arbiter.sv - randomized scoreboard bench for roach_dram_arbiter
module tb_roach_dram_arbiter;
  localparam int AW        = 25;
  localparam int DW        = 288;
  localparam int MAX_BURST = 64;
  localparam int TAG_DEPTH = 16;
  localparam int RD_BEATS  = 2;

  typedef struct {
    logic          rwn;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          last;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_wdata;
  logic          dram_rwn;
  logic          dram_cmd_valid;
  logic          dram_cmd_ack;
  logic [DW-1:0] dram_rd_data;
  logic          dram_rd_valid;
  logic [1:0]    grant;
  logic          rd_err;

  roach_dram_arbiter_if #(.ADDR_WIDTH(AW)) a_if ();
  roach_dram_arbiter_if #(.ADDR_WIDTH(AW)) b_if ();

  roach_dram_arbiter #(
    .ADDR_WIDTH(AW),
    .MAX_BURST (MAX_BURST),
    .TAG_DEPTH (TAG_DEPTH),
    .RD_BEATS  (RD_BEATS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .a             (a_if),
    .b             (b_if),
    .dram_addr     (dram_addr),
    .dram_wdata    (dram_wdata),
    .dram_rwn      (dram_rwn),
    .dram_cmd_valid(dram_cmd_valid),
    .dram_cmd_ack  (dram_cmd_ack),
    .dram_rd_data  (dram_rd_data),
    .dram_rd_valid (dram_rd_valid),
    .grant         (grant),
    .rd_err        (rd_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  cmd_t cq[2][$];
  int   tags[$];
  int   burst_lens[$];
  int   owner_seq[$];
  int   owner, ptr, burst_len, beats, pend_beats;
  int   ack_pct, ret_pct, gap_pct, low_from, low_to;
  int   cyc, first_acc_cyc, last_acc_cyc, rv_a, rv_b;
  bit   model_err, expect_idle, stray;
  logic [DW-1:0] rd_drv;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] seq_bits();
    logic [7:0] s = '0;
    for (int i = 0; i < owner_seq.size() && i < 8; i++) s[i] = (owner_seq[i] == 1);
    return s;
  endfunction

  function automatic bit all_done();
    return cq[0].size() == 0 && cq[1].size() == 0 && pend_beats == 0 && tags.size() == 0;
  endfunction

  task automatic push_cmd(input int c, input logic rwn, input logic [AW-1:0] addr, input logic last);
    cmd_t x;
    x.rwn   = rwn;
    x.addr  = addr;
    x.wdata = rnd_data();
    x.last  = last;
    cq[c].push_back(x);
  endtask

  task automatic idle_inputs();
    a_if.valid = 1'b0; a_if.rwn = 1'b0; a_if.addr = '0; a_if.wdata = '0; a_if.last = 1'b0;
    b_if.valid = 1'b0; b_if.rwn = 1'b0; b_if.addr = '0; b_if.wdata = '0; b_if.last = 1'b0;
    dram_cmd_ack  = 1'b0;
    dram_rd_valid = 1'b0;
    dram_rd_data  = '0;
  endtask

  task automatic drive_inputs();
    idle_inputs();
    if (cq[0].size() > 0) begin
      a_if.valid = !(owner == 0 && pct(gap_pct));
      a_if.rwn   = cq[0][0].rwn;
      a_if.addr  = cq[0][0].addr;
      a_if.wdata = cq[0][0].wdata;
      a_if.last  = cq[0][0].last;
    end
    if (cq[1].size() > 0) begin
      b_if.valid = !(owner == 1 && pct(gap_pct));
      b_if.rwn   = cq[1][0].rwn;
      b_if.addr  = cq[1][0].addr;
      b_if.wdata = cq[1][0].wdata;
      b_if.last  = cq[1][0].last;
    end
    dram_cmd_ack  = (cyc >= low_from && cyc < low_to) ? 1'b0 : pct(ack_pct);
    dram_rd_valid = stray || (pend_beats > 0 && pct(ret_pct));
    rd_drv        = rnd_data();
    dram_rd_data  = rd_drv;
  endtask

  // Scoreboard for one accepted command: ownership, round-robin order, port mux, burst release.
  task automatic accept(input int c);
    cmd_t h;
    int   n0, n1, exp_owner;
    n0 = cq[0].size();
    n1 = cq[1].size();
    h  = cq[c].pop_front();
    if (owner < 0) begin
      exp_owner = (n0 > 0 && n1 > 0) ? ptr : ((n0 > 0) ? 0 : 1);
      chk("rr_owner", c, exp_owner);
      chk("grant_start", grant, (c == 0) ? 2'b01 : 2'b10);
      owner     = c;
      burst_len = 0;
      owner_seq.push_back(c);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
    end
    last_acc_cyc = cyc;
    chk("dram_addr", dram_addr, h.addr);
    chk("dram_rwn", dram_rwn, h.rwn);
    chk("cmd_valid", dram_cmd_valid, 1'b1);
    if (!h.rwn) chk("dram_wdata", dram_wdata, h.wdata);
    if (h.rwn) begin
      tags.push_back(c);
      pend_beats += RD_BEATS;
    end
    burst_len++;
    if (h.last || burst_len == MAX_BURST) begin
      burst_lens.push_back(burst_len);
      owner       = -1;
      ptr         = 1 - c;
      expect_idle = 1'b1;
    end
  endtask

  task automatic cycle();
    logic [1:0] rdy, vld;
    @(posedge clk);
    #1;
    drive_inputs();
    #3;
    rdy = {b_if.ready, a_if.ready};
    vld = {b_if.valid, a_if.valid};
    chk("both_ready", (rdy == 2'b11), 1'b0);
    chk("rd_err", rd_err, model_err);
    if (!dram_cmd_ack) chk("ready_wo_ack", |rdy, 1'b0);
    if (expect_idle) begin
      chk("idle_bubble", grant, 2'b00);
      chk("idle_ready", |rdy, 1'b0);
      expect_idle = 1'b0;
    end
    if (owner >= 0) begin
      chk("grant_hold", grant, (owner == 0) ? 2'b01 : 2'b10);
      chk("other_ready", rdy[1-owner], 1'b0);
      if (vld[owner]) begin
        chk("addr_hold", dram_addr, cq[owner][0].addr);
        if (dram_cmd_ack)
          chk("ready", rdy[owner], !(cq[owner][0].rwn && tags.size() == TAG_DEPTH));
      end else begin
        chk("gap_cmd_valid", dram_cmd_valid, 1'b0);
      end
    end
    if (rdy[0] && vld[0]) accept(0);
    if (rdy[1] && vld[1]) accept(1);
    if (dram_rd_valid) begin
      if (tags.size() > 0) begin
        chk("a_rvalid", a_if.rvalid, tags[0] == 0);
        chk("b_rvalid", b_if.rvalid, tags[0] == 1);
        chk("rdata", (tags[0] == 0) ? a_if.rdata : b_if.rdata, rd_drv);
        if (a_if.rvalid) rv_a++;
        if (b_if.rvalid) rv_b++;
        beats++;
        pend_beats--;
        if (beats == RD_BEATS) begin
          beats = 0;
          void'(tags.pop_front());
        end
      end else begin
        chk("stray_rvalid", a_if.rvalid | b_if.rvalid, 1'b0);
        model_err = 1'b1;
      end
    end else begin
      chk("rvalid_quiet", a_if.rvalid | b_if.rvalid, 1'b0);
    end
    cyc++;
    stray = 1'b0;
  endtask

  task automatic run(input int max_cyc);
    int n = 0;
    cyc = 0;
    first_acc_cyc = -1;
    while (!all_done() && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("run_done", all_done(), 1'b1);
  endtask

  task automatic run_fixed(input int n);
    cyc = 0;
    first_acc_cyc = -1;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    chk("rst_grant_drop", grant, 2'b00);
    @(posedge clk);
    #1;
    chk("rst_ready", {b_if.ready, a_if.ready}, 2'b00);
    chk("rst_cmd_valid", dram_cmd_valid, 1'b0);
    chk("rst_rwn", dram_rwn, 1'b1);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_rvalid", {b_if.rvalid, a_if.rvalid}, 2'b00);
    rst = 1'b0;
    cq[0].delete();
    cq[1].delete();
    tags.delete();
    burst_lens.delete();
    owner_seq.delete();
    owner = -1; ptr = 0; burst_len = 0; beats = 0; pend_beats = 0;
    model_err = 1'b0; expect_idle = 1'b0; stray = 1'b0;
    rv_a = 0; rv_b = 0; cyc = 0;
    ack_pct = 100; ret_pct = 100; gap_pct = 0; low_from = -1; low_to = -1;
  endtask

  initial begin
    owner = -1;
    cyc   = 0;
    low_from = -1;
    low_to   = -1;
    do_reset();

    // A alone: four reads, grant one cycle after valid, then ptr moves to B.
    for (int i = 0; i < 4; i++) push_cmd(0, 1'b1, AW'(i), i == 3);
    run(200);
    chk("s1_latency", first_acc_cyc, 1);
    chk("s1_len", burst_lens[0], 4);
    push_cmd(0, 1'b0, AW'(10), 1'b1);
    push_cmd(1, 1'b0, AW'(20), 1'b1);
    run(200);
    chk("s1_order", seq_bits(), 8'b010);
    chk("s1_bursts", owner_seq.size(), 3);

    // Both clients, two 3-command bursts each, alternating with a bubble.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 3; i++) push_cmd(c, 1'($urandom_range(1)), AW'($urandom), i == 2);
    run(300);
    chk("s2_order", seq_bits(), 8'b1010);
    chk("s2_bursts", owner_seq.size(), 4);

    // Long A stream without last is cut at MAX_BURST, B gets a turn.
    do_reset();
    for (int i = 0; i < 100; i++) push_cmd(0, 1'b0, AW'(i), 1'b0);
    for (int i = 0; i < 3; i++) push_cmd(1, 1'b0, AW'(500 + i), i == 2);
    run(1000);
    chk("s3_first_len", burst_lens[0], MAX_BURST);
    chk("s3_b_len", burst_lens[1], 3);
    chk("s3_order", seq_bits(), 8'b010);

    // DRAM ack held low for five cycles mid-burst.
    do_reset();
    for (int i = 0; i < 6; i++) push_cmd(0, 1'b0, AW'(100 + i), i == 5);
    low_from = 3;
    low_to   = 8;
    run(200);
    chk("s4_last_acc", last_acc_cyc, 11);
    chk("s4_len", burst_lens[0], 6);

    // Two A reads then one B read; six beats routed 4 to A, 2 to B.
    do_reset();
    push_cmd(0, 1'b1, AW'(1), 1'b0);
    push_cmd(0, 1'b1, AW'(2), 1'b1);
    push_cmd(1, 1'b1, AW'(3), 1'b1);
    ret_pct = 0;
    run_fixed(8);
    ret_pct = 100;
    run(100);
    chk("s5_a_beats", rv_a, 4);
    chk("s5_b_beats", rv_b, 2);

    // Tag FIFO full stalls the 17th read until a return completes; then a stray beat.
    do_reset();
    for (int i = 0; i < TAG_DEPTH + 1; i++) push_cmd(0, 1'b1, AW'(i), i == TAG_DEPTH);
    ret_pct = 0;
    run_fixed(30);
    chk("s6_stalled", cq[0].size(), 1);
    ret_pct = 100;
    run(300);
    stray = 1'b1;
    cycle();
    cycle();
    chk("s6_rd_err", rd_err, 1'b1);

    // Reset mid-burst discards tags; a late return afterwards flags rd_err.
    do_reset();
    for (int i = 0; i < 4; i++) push_cmd(0, 1'b1, AW'(i), i == 3);
    ret_pct = 0;
    run_fixed(3);
    do_reset();
    stray = 1'b1;
    cycle();
    cycle();
    chk("s7_late_rd_err", rd_err, 1'b1);

    // Random traffic with random acks, returns and valid gaps.
    do_reset();
    ack_pct = 70;
    ret_pct = 40;
    gap_pct = 15;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 120; i++)
        push_cmd(c, 1'($urandom_range(1)), AW'($urandom), (i == 119) || pct(25));
    run(8000);
    chk("s8_rd_err", rd_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
